// File: rtl/hqm_mem_rf_pg_seq.sv
// Register-file macro with a power-gate sequencer.
// The sequencer handles wake, isolation release, a post-wake zero sweep, drain and sleep.
module hqm_mem_rf_pg_seq #(
  parameter int DEPTH    = 512,
  parameter int DWIDTH   = 17,
  parameter int AWIDTH   = $clog2(DEPTH),
  parameter int RD_LAT   = 1,
  parameter int WAKE_CYC = 8,
  parameter int INIT_EN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwr_on_req,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata,
  output logic              rvalid,
  output logic              ready,
  output logic              access_err,
  output logic              pwr_enable_b,
  output logic              isol_en,
  output logic [2:0]        pg_state
);

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_WAKE  = 3'd1,
    ST_INIT  = 3'd2,
    ST_ON    = 3'd3,
    ST_DRAIN = 3'd4,
    ST_ISO   = 3'd5
  } pg_state_e;

  // One shared down-counter serves both the wake delay and the read drain.
  localparam int CW = (WAKE_CYC > 2) ? $clog2(WAKE_CYC) : 1;
  localparam logic [AWIDTH:0]   DEPTH_X   = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  pg_state_e         state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [AWIDTH-1:0] init_addr_reg, init_addr_next;

  logic [DWIDTH-1:0] mem [0:DEPTH-1];
  logic              wr_acc, rd_acc, dropped;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] rdata_reg;
  logic              rvalid_reg, access_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_OFF;
      cnt_reg       <= '0;
      init_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      init_addr_reg <= init_addr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    init_addr_next = init_addr_reg;
    case (state_reg)
      ST_OFF: begin
        if (pwr_on_req) begin
          state_next = ST_WAKE;
          cnt_next   = CW'(WAKE_CYC - 1);
        end
      end
      ST_WAKE: begin
        if (cnt_reg == '0) begin
          state_next     = (INIT_EN != 0) ? ST_INIT : ST_ON;
          init_addr_next = '0;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      ST_INIT: begin
        if (init_addr_reg == LAST_ADDR) begin
          state_next     = ST_ON;
          init_addr_next = '0;
        end else begin
          init_addr_next = init_addr_reg + AWIDTH'(1);
        end
      end
      ST_ON: begin
        if (!pwr_on_req) begin
          state_next = ST_DRAIN;
          cnt_next   = CW'(RD_LAT - 1);
        end
      end
      ST_DRAIN: begin
        if (cnt_reg == '0) state_next = ST_ISO;
        else               cnt_next   = cnt_reg - CW'(1);
      end
      ST_ISO:  state_next = ST_OFF;
      default: state_next = ST_OFF;
    endcase
  end

  always_comb begin
    pwr_enable_b = (state_reg == ST_OFF);
    isol_en      = (state_reg == ST_OFF) || (state_reg == ST_WAKE) || (state_reg == ST_ISO);
    ready        = (state_reg == ST_ON);
  end

  assign pg_state = state_reg;

  assign wr_acc  = ready && we && ({1'b0, waddr} < DEPTH_X);
  assign rd_acc  = ready && re && ({1'b0, raddr} < DEPTH_X);
  assign dropped = (we && !wr_acc) || (re && !rd_acc);

  // The zero sweep and client writes never overlap: writes need ready, INIT has none.
  always_comb begin
    mem_we    = wr_acc;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (state_reg == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_addr_reg;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) access_err_reg <= 1'b0;
    else        access_err_reg <= dropped;
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rvalid_reg <= 1'b0;
          rdata_reg  <= '0;
        end else begin
          rvalid_reg <= rd_acc;
          if (rd_acc) rdata_reg <= mem[raddr];
        end
      end
    end else begin : g_lat2
      logic [DWIDTH-1:0] rd_q;
      logic              rd_q_vld;
      // Non-reset RAM output stage; the reset-able register behind it holds the last value.
      always_ff @(posedge clk) begin
        if (rd_acc) rd_q <= mem[raddr];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_q_vld   <= 1'b0;
          rvalid_reg <= 1'b0;
          rdata_reg  <= '0;
        end else begin
          rd_q_vld   <= rd_acc;
          rvalid_reg <= rd_q_vld;
          if (rd_q_vld) rdata_reg <= rd_q;
        end
      end
    end
  endgenerate

  assign rdata      = rdata_reg;
  assign rvalid     = rvalid_reg;
  assign access_err = access_err_reg;

endmodule
